// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states, opcode classification.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // Opcode map carried over from the single-cycle ALU.
    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_MUL   = 6'h02;
    localparam logic [5:0] OP_DIV   = 6'h03;
    localparam logic [5:0] OP_MOD   = 6'h04;
    localparam logic [5:0] OP_AND   = 6'h05;
    localparam logic [5:0] OP_NAND  = 6'h06;
    localparam logic [5:0] OP_NOR   = 6'h07;
    localparam logic [5:0] OP_NOT   = 6'h08;
    localparam logic [5:0] OP_OR    = 6'h09;
    localparam logic [5:0] OP_XNOR  = 6'h0A;
    localparam logic [5:0] OP_SGT   = 6'h0B;
    localparam logic [5:0] OP_SGET  = 6'h0C;
    localparam logic [5:0] OP_SLT   = 6'h0D;
    localparam logic [5:0] OP_SLTEQ = 6'h0E;
    localparam logic [5:0] OP_SLL   = 6'h0F;
    localparam logic [5:0] OP_SLR   = 6'h10;
    localparam logic [5:0] OP_XOR   = 6'h11;

    // Top-level FSM states.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ITER = 2'd1;
    localparam state_t DONE = 2'd2;

    // Operations that go through the bit-serial engine.
    function automatic logic is_iterative(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Bit-serial engine: shift-add multiply and restoring divide, one bit per cycle.
// Latency: WIDTH cycles after start; done flags the final step, outputs show post-step values.
// Backpressure: none; caller issues start only when idle and captures on done.
module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mode,          // 0: multiply, 1: divide
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot_or_prod,
    output logic [WIDTH-1:0] rem
);

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH - 1);

    logic [SHW:0]     cnt;
    logic             mode_q;
    logic [WIDTH-1:0] sh;       // multiplier bits (mul) / dividend-then-quotient (div)
    logic [WIDTH-1:0] acc;      // product (mul) / partial remainder (div)
    logic [WIDTH-1:0] opnd;     // shifted multiplicand (mul) / divisor (div)

    logic [WIDTH-1:0] sh_nxt, acc_nxt, opnd_nxt;
    logic [WIDTH:0]   r_sh, diff;

    // One iteration step for whichever mode is active.
    always_comb begin
        r_sh     = {acc, sh[WIDTH-1]};
        diff     = r_sh - {1'b0, opnd};
        sh_nxt   = sh;
        acc_nxt  = acc;
        opnd_nxt = opnd;
        if (mode_q) begin
            // Restoring division: keep the subtraction only when it did not borrow.
            acc_nxt = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            sh_nxt  = {sh[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            acc_nxt  = sh[0] ? (acc + opnd) : acc;
            sh_nxt   = sh >> 1;
            opnd_nxt = opnd << 1;
        end
    end

    assign done         = busy && (cnt == '0);
    assign quot_or_prod = mode_q ? sh_nxt : acc_nxt;
    assign rem          = acc_nxt;

    // Load operands on start, then step once per cycle until the counter runs out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            sh     <= '0;
            acc    <= '0;
            opnd   <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CNT_INIT;
            mode_q <= mode;
            sh     <= mode ? op_a : op_b;
            acc    <= '0;
            opnd   <= mode ? op_b : op_a;
        end else if (busy) begin
            busy <= (cnt != '0);
            cnt  <= cnt - {{SHW{1'b0}}, 1'b1};
            sh   <= sh_nxt;
            acc  <= acc_nxt;
            opnd <= opnd_nxt;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshake; single-cycle ops plus bit-serial mul/div/mod.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for mul/div/mod.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    input  logic [5:0]       aluOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero
);

    state_t           state;
    logic             is_mod_q;
    logic             accept, dz, go_iter, shift_oob;
    logic [WIDTH-1:0] sc_res, it_val;
    logic             it_busy, it_done;
    logic [WIDTH-1:0] it_qp, it_rem;

    assign in_ready  = reset_n && (state == IDLE) && !it_busy;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign dz        = ((aluOp == OP_DIV) || (aluOp == OP_MOD)) && (regB == '0);
    assign go_iter   = accept && is_iterative(aluOp) && !dz;
    assign shift_oob = |(regB >> SHW);
    assign it_val    = is_mod_q ? it_rem : it_qp;

    seq_alu_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (go_iter),
        .op_a         (regA),
        .op_b         (regB),
        .mode         (aluOp != OP_MUL),
        .busy         (it_busy),
        .done         (it_done),
        .quot_or_prod (it_qp),
        .rem          (it_rem)
    );

    // Single-cycle result mux, including the divide-by-zero shortcuts.
    always_comb begin
        sc_res = regA;
        case (aluOp)
            OP_ADD:   sc_res = regA + regB;
            OP_SUB:   sc_res = regA - regB;
            OP_AND:   sc_res = regA & regB;
            OP_NAND:  sc_res = ~(regA & regB);
            OP_NOR:   sc_res = ~(regA | regB);
            OP_NOT:   sc_res = ~regA;
            OP_OR:    sc_res = regA | regB;
            OP_XOR:   sc_res = regA ^ regB;
            OP_XNOR:  sc_res = ~(regA ^ regB);
            OP_SGT:   sc_res = WIDTH'(regA >  regB);
            OP_SGET:  sc_res = WIDTH'(regA >= regB);
            OP_SLT:   sc_res = WIDTH'(regA <  regB);
            OP_SLTEQ: sc_res = WIDTH'(regA <= regB);
            OP_SLL:   sc_res = shift_oob ? '0 : (regA << regB[SHW-1:0]);
            OP_SLR:   sc_res = shift_oob ? '0 : (regA >> regB[SHW-1:0]);
            OP_DIV:   sc_res = '1;
            default:  sc_res = regA;
        endcase
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            is_mod_q    <= 1'b0;
            result      <= '0;
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_iter) begin
                        state    <= ITER;
                        is_mod_q <= (aluOp == OP_MOD);
                    end else if (accept) begin
                        state       <= DONE;
                        result      <= sc_res;
                        zero        <= (sc_res == '0);
                        div_by_zero <= dz;
                    end
                end
                ITER: begin
                    if (it_done) begin
                        state       <= DONE;
                        result      <= it_val;
                        zero        <= (it_val == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls in DONE.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        iv32 = 1'b0, iv8 = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] regA = '0, regB = '0;
    logic [5:0]  aluOp = '0;

    logic        ir32, ov32, zr32, dz32;
    logic [31:0] res32;
    logic        ir8, ov8, zr8, dz8;
    logic [7:0]  res8;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_alu #(.WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
        .regA(regA), .regB(regB), .aluOp(aluOp), .out_valid(ov32),
        .out_ready(out_ready), .result(res32), .zero(zr32), .div_by_zero(dz32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .regA(regA[7:0]), .regB(regB[7:0]), .aluOp(aluOp), .out_valid(ov8),
        .out_ready(out_ready), .result(res8), .zero(zr8), .div_by_zero(dz8)
    );

    function automatic logic g_ov(input bit sel);  return sel ? ov8 : ov32; endfunction
    function automatic logic g_ir(input bit sel);  return sel ? ir8 : ir32; endfunction
    function automatic logic g_zr(input bit sel);  return sel ? zr8 : zr32; endfunction
    function automatic logic g_dz(input bit sel);  return sel ? dz8 : dz32; endfunction
    function automatic logic [31:0] g_res(input bit sel); return sel ? {24'd0, res8} : res32; endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit unsigned values.
    task automatic model(input logic [5:0] op, input logic [31:0] a_in, input logic [31:0] b_in,
                         input int w, output logic [63:0] r, output logic dbz, output int lat);
        logic [63:0] mask, a, b;
        mask = (64'd1 << w) - 64'd1;
        a = {32'd0, a_in} & mask;
        b = {32'd0, b_in} & mask;
        dbz = 1'b0;
        lat = 1;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_MUL:   begin r = a * b; lat = w + 1; end
            OP_DIV:   if (b == 0) begin r = mask; dbz = 1'b1; end else begin r = a / b; lat = w + 1; end
            OP_MOD:   if (b == 0) begin r = a;    dbz = 1'b1; end else begin r = a % b; lat = w + 1; end
            OP_AND:   r = a & b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_NOT:   r = ~a;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            OP_SGT:   r = (a >  b) ? 64'd1 : 64'd0;
            OP_SGET:  r = (a >= b) ? 64'd1 : 64'd0;
            OP_SLT:   r = (a <  b) ? 64'd1 : 64'd0;
            OP_SLTEQ: r = (a <= b) ? 64'd1 : 64'd0;
            OP_SLL:   r = (b >= 64'(w)) ? 64'd0 : (a << b);
            OP_SLR:   r = (b >= 64'(w)) ? 64'd0 : (a >> b);
            default:  r = a;
        endcase
        r = r & mask;
    endtask

    // Issue one op, check latency/result/flags, optionally stall in DONE, then check return to IDLE.
    task automatic run_op(input bit sel, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall, input string tag);
        logic [63:0] er;
        logic        edz;
        int          elat, n, busy_rdy;
        model(op, a, b, sel ? 8 : 32, er, edz, elat);
        @(negedge clock);
        chk({tag, "_in_ready"}, 64'(g_ir(sel)), 64'd1);
        regA = a; regB = b; aluOp = op;
        if (sel) iv8 = 1'b1; else iv32 = 1'b1;
        @(posedge clock);
        #1;
        iv8 = 1'b0; iv32 = 1'b0;
        regA = $urandom; regB = $urandom; aluOp = 6'($urandom);
        n = 1;
        busy_rdy = 0;
        while (n <= 200) begin
            @(negedge clock);
            if (g_ov(sel)) break;
            if (g_ir(sel)) busy_rdy++;
            @(posedge clock);
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(elat));
        chk({tag, "_busy_in_ready"}, 64'(busy_rdy), 64'd0);
        chk({tag, "_result"}, {32'd0, g_res(sel)}, er);
        chk({tag, "_zero"}, 64'(g_zr(sel)), 64'(er == 64'd0));
        chk({tag, "_dbz"}, 64'(g_dz(sel)), 64'(edz));
        for (int i = 0; i < stall; i++) begin
            regA = $urandom; regB = $urandom; aluOp = OP_ADD;
            if (sel) iv8 = 1'b1; else iv32 = 1'b1;
            @(posedge clock);
            @(negedge clock);
            chk({tag, "_stall_valid"}, 64'(g_ov(sel)), 64'd1);
            chk({tag, "_stall_result"}, {32'd0, g_res(sel)}, er);
            chk({tag, "_stall_in_ready"}, 64'(g_ir(sel)), 64'd0);
        end
        iv8 = 1'b0; iv32 = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        chk({tag, "_idle_valid"}, 64'(g_ov(sel)), 64'd0);
        chk({tag, "_idle_in_ready"}, 64'(g_ir(sel)), 64'd1);
    endtask

    initial begin
        int seen_valid;
        logic [31:0] ra, rb;

        // Reset values while held and after release.
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", 64'(ir32), 64'd0);
        chk("rst_out_valid", 64'(ov32), 64'd0);
        chk("rst_result", 64'(res32), 64'd0);
        chk("rst_zero", 64'(zr32), 64'd1);
        chk("rst_dbz", 64'(dz32), 64'd0);
        chk("rst8_result", 64'(res8), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_in_ready", 64'(ir32), 64'd1);
        chk("rel8_in_ready", 64'(ir8), 64'd1);

        // Directed cases at WIDTH=32.
        run_op(0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 0, "add_wrap");
        run_op(0, OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, "and");
        run_op(0, OP_SLT, 32'd3, 32'd5, 0, "slt");
        run_op(0, OP_SLL, 32'd1, 32'd35, 0, "sll_oob");
        run_op(0, OP_SLL, 32'd1, 32'd31, 0, "sll_31");
        run_op(0, OP_DIV, 32'd100, 32'd7, 0, "div");
        run_op(0, OP_MOD, 32'd100, 32'd7, 0, "mod");
        run_op(0, OP_DIV, 32'd5, 32'd0, 0, "div0");
        run_op(0, OP_MOD, 32'd5, 32'd0, 0, "mod0");
        run_op(0, OP_NAND, 32'h1234_5678, 32'hFFFF_0000, 10, "backpressure");
        run_op(0, OP_MUL, 32'h0001_0000, 32'h0001_0001, 0, "mul");
        chk("mul_const", 64'(res32), 64'h0001_0000);

        // Reset asserted ten cycles into a divide aborts it.
        @(negedge clock);
        regA = 32'd1000; regB = 32'd3; aluOp = OP_DIV; iv32 = 1'b1;
        @(posedge clock);
        #1 iv32 = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(ov32), 64'd0);
        chk("abort_result", 64'(res32), 64'd0);
        chk("abort_zero", 64'(zr32), 64'd1);
        chk("abort_in_ready", 64'(ir32), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (ov32) seen_valid++;
        end
        chk("abort_no_valid", 64'(seen_valid), 64'd0);
        chk("abort_in_ready_after", 64'(ir32), 64'd1);

        // Directed cases at WIDTH=8.
        run_op(1, OP_MUL, 32'd15, 32'd17, 0, "w8_mul");
        chk("w8_mul_const", 64'(res8), 64'hFF);
        run_op(1, OP_DIV, 32'd200, 32'd7, 0, "w8_div");
        run_op(1, OP_MOD, 32'd200, 32'd7, 0, "w8_mod");
        run_op(1, OP_DIV, 32'd9, 32'd0, 0, "w8_div0");
        run_op(1, OP_SLR, 32'h80, 32'd8, 0, "w8_slr_oob");
        run_op(1, OP_SUB, 32'd0, 32'd1, 3, "w8_sub_wrap");

        // Randomized ops on both widths, including unmapped opcodes.
        for (int k = 0; k < 60; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(0, 40);
                default: rb = $urandom;
            endcase
            run_op(bit'(k % 2), 6'($urandom_range(0, 19)), ra, rb, $urandom_range(0, 2), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised successor to the datapath's single-cycle ALU. It keeps the 6-bit opcode map and adds a `WIDTH` parameter, a valid/ready handshake on input and output, registered results, and true bitwise logic ops. Multiply, divide and modulo are computed iteratively, one bit per cycle, instead of as combinational operators. The block sits in the execute stage, between operand fetch and writeback, and stalls the pipeline through the handshake.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, never overridden.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  block can accept an operation.
- `regA`  in  WIDTH  operand A.
- `regB`  in  WIDTH  operand B.
- `aluOp`  in  6  opcode; same encoding as the existing ALU.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`; registered together with `result`.
- `div_by_zero`  out  1  a div/mod was issued with `regB == 0`; valid with `out_valid`.

## Operation
- **States:**
  - IDLE: `in_ready = 1`.
  - ITER: mul/div/mod in progress.
  - DONE: `out_valid = 1`.
- **Accept:** an operation is accepted when `in_valid && in_ready`. At accept, `regA`, `regB` and `aluOp` are captured. Later changes on those inputs are ignored.
- **Single-cycle ops** (add, sub, and, nand, nor, not, or, xor, xnor, sgt, sget, slt, slteq, sll, slr, default): result is computed at accept and registered. State goes IDLE→DONE.
- **Logic ops are bitwise, WIDTH bits wide:**
  - and = A&B, nand = ~(A&B), nor = ~(A|B), not = ~A, or = A|B, xnor = ~(A^B), xor = A^B.
- **Comparisons:** unsigned. The result is zero-extended 1 or 0.
- **add/sub:** modulo 2^WIDTH; the carry is discarded.
- **sll/slr:** logical shifts by `regB[SHW-1:0]`. If any bit of `regB` above `SHW-1` is set, the result is 0.
- **mul:** shift-add, one bit of B per cycle, WIDTH cycles. Result is the low WIDTH bits of the product.
- **div/mod:** unsigned restoring division, one quotient bit per cycle, WIDTH cycles. div returns the quotient; mod returns the remainder.
- **Divide by zero:**
  - No iteration is performed; state goes straight to DONE.
  - `div_by_zero = 1`.
  - div returns all ones; mod returns `regA`.
- **Unmapped opcodes:** result = `regA`, single-cycle.
- **DONE:**
  - `result`, `zero` and `div_by_zero` are held stable until `out_valid && out_ready`.
  - The cycle after that handshake, state returns to IDLE.
  - `in_ready = 0` in DONE; there is no same-cycle re-accept.

## Timing
- **Reset values:** `in_ready = 0` while `reset_n` is low; `out_valid = 0`, `result = 0`, `zero = 1`, `div_by_zero = 0`. State = IDLE, so `in_ready = 1` after release.
- **Latency**, with the accept edge as cycle 0:
  - single-cycle ops and div/mod by zero: `out_valid` = 1 at cycle 1;
  - mul/div/mod: `out_valid` = 1 at cycle WIDTH+1.
- **Throughput:**
  - single-cycle ops: one op per 2 cycles when `out_ready` is held high;
  - iterative ops: one op per WIDTH+2 cycles.
- **Iteration counter:** SHW+1 bits, loaded with WIDTH-1, decremented each ITER cycle. ITER→DONE happens when the counter reaches 0.
- **Reset mid-ITER or mid-DONE:** the operation is aborted immediately and asynchronously, and no `out_valid` is produced. After release the block is in IDLE with reset output values.
- **`out_ready` outside DONE:** ignored.
- **`in_valid` outside IDLE:** ignored; the upstream stage holds its data until `in_ready` is high.

## Structure
- **`alu_pkg`:**
  - opcode localparams `OP_ADD` … `OP_XOR` (6'h00–6'h11);
  - state typedef {IDLE, ITER, DONE};
  - function `is_iterative(op)`.
- **Sub-module `seq_alu_iter`:**
  - shared shift register, accumulator and counter for mul and restoring div/mod;
  - interface: `start`, operands, mode, `busy`, `done`, `quot_or_prod`, `rem`.
- **Top level:** FSM, single-cycle operation mux, output registers.

## Test plan
- **Reset:** hold `reset_n` low, then release → `in_ready = 1`, `out_valid = 0`, `result = 0`, `zero = 1`.
- **Single-cycle ops, WIDTH=32:**
  - add 0xFFFFFFFF+1 → `result = 0`, `zero = 1`, `out_valid` at cycle 1;
  - and 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0;
  - slt 3<5 → 1;
  - sll 1 by 35 → 0.
- **Multiply, WIDTH=32:** mul 0x10000 × 0x10001 → 0x00010000 (low word); `out_valid` at cycle 33; `in_ready = 0` for cycles 1–33.
- **Divide and modulo:**
  - div 100/7 → 14; mod 100 % 7 → 2; 33-cycle latency;
  - div 5/0 → 0xFFFFFFFF, `div_by_zero = 1`, `out_valid` at cycle 1.
- **Backpressure:** hold `out_ready = 0` for 10 cycles in DONE → `result` stays stable and `in_valid` is ignored. Raise `out_ready` → IDLE on the next cycle.
- **Reset during ITER, and WIDTH=8 rerun:**
  - assert `reset_n` at cycle 10 of a div → outputs return to reset values and no `out_valid` appears;
  - rerun the suite at WIDTH=8: mul 15×17 → 0xFF, 9-cycle latency.
